hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// ID-stage hazard unit for a 5-stage pipeline with branches resolved in ID.
// Tracks EX/MEM destinations, detects load-use and branch hazards, and counts stalls/flushes.
module hazard_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Inst,
  input  logic        Taken,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        Bubble,
  output logic        IFIDFlush,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);

  localparam logic [5:0] OP_RT   = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd1;
  localparam logic [5:0] OP_SLTI = 6'd2;
  localparam logic [5:0] OP_LW   = 6'd3;
  localparam logic [5:0] OP_SW   = 6'd4;
  localparam logic [5:0] OP_BEQ  = 6'd5;
  localparam logic [5:0] OP_J    = 6'd6;
  localparam logic [5:0] OP_JR   = 6'd7;
  localparam logic [5:0] OP_JAL  = 6'd8;

  // Register zero is hardwired, so it can never carry a dependence.
  function automatic logic src_match(input logic use_f, input logic [4:0] src,
                                     input logic [4:0] dst);
    return use_f && (src == dst) && (dst != 5'd0);
  endfunction

  logic [5:0] opc_s;
  logic [4:0] rs_s, rt_s, rd_s, dst_s;
  logic       use_a_s, use_b_s, wr_s, is_lw_s, is_br_s, is_beq_s, is_jmp_s;
  logic       ex_hit_s, mem_hit_s, stall_s, flush_s;

  logic       ex_wr_q, ex_lw_q, mem_lw_q;
  logic [4:0] ex_dst_q, mem_dst_q;
  logic       ex_wr_d, ex_lw_d;
  logic [4:0] ex_dst_d;
  logic [15:0] stall_cnt_q, flush_cnt_q, stall_cnt_d, flush_cnt_d;

  assign opc_s = Inst[31:26];
  assign rs_s  = Inst[25:21];
  assign rt_s  = Inst[20:16];
  assign rd_s  = Inst[15:11];

  // Opcode decode: source usage, writeback destination, control-flow class
  always_comb begin
    use_a_s  = 1'b0;
    use_b_s  = 1'b0;
    wr_s     = 1'b0;
    is_lw_s  = 1'b0;
    is_br_s  = 1'b0;
    is_beq_s = 1'b0;
    is_jmp_s = 1'b0;
    dst_s    = rt_s;
    case (opc_s)
      OP_RT:   begin use_a_s = 1'b1; use_b_s = 1'b1; wr_s = 1'b1; dst_s = rd_s; end
      OP_ADDI: begin use_a_s = 1'b1; wr_s = 1'b1; end
      OP_SLTI: begin use_a_s = 1'b1; wr_s = 1'b1; end
      OP_LW:   begin use_a_s = 1'b1; wr_s = 1'b1; is_lw_s = 1'b1; end
      OP_SW:   begin use_a_s = 1'b1; use_b_s = 1'b1; end
      OP_BEQ:  begin use_a_s = 1'b1; use_b_s = 1'b1; is_br_s = 1'b1; is_beq_s = 1'b1; end
      OP_J:    begin is_jmp_s = 1'b1; end
      OP_JR:   begin use_a_s = 1'b1; is_br_s = 1'b1; is_jmp_s = 1'b1; end
      OP_JAL:  begin wr_s = 1'b1; dst_s = 5'd31; is_jmp_s = 1'b1; end
      default: begin use_a_s = 1'b0; use_b_s = 1'b0; wr_s = 1'b0; end
    endcase
  end

  assign ex_hit_s  = src_match(use_a_s, rs_s, ex_dst_q)  || src_match(use_b_s, rt_s, ex_dst_q);
  assign mem_hit_s = src_match(use_a_s, rs_s, mem_dst_q) || src_match(use_b_s, rt_s, mem_dst_q);

  // Branches compare in ID, so they also wait on ALU results in EX and loads in MEM.
  assign stall_s = (ex_lw_q && ex_hit_s) ||
                   (is_br_s && ((ex_wr_q && ex_hit_s) || (mem_lw_q && mem_hit_s)));
  assign flush_s = !stall_s && (is_jmp_s || (is_beq_s && Taken));

  // Pipeline control outputs; reset holds the front end frozen
  always_comb begin
    if (rst) begin
      PCWrite = 1'b0; IFIDWrite = 1'b0; Bubble = 1'b1; IFIDFlush = 1'b0;
    end else if (stall_s) begin
      PCWrite = 1'b0; IFIDWrite = 1'b0; Bubble = 1'b1; IFIDFlush = 1'b0;
    end else begin
      PCWrite = 1'b1; IFIDWrite = 1'b1; Bubble = 1'b0; IFIDFlush = flush_s;
    end
  end

  // Next-state for EX tracking and saturating event counters
  always_comb begin
    ex_wr_d     = 1'b0;
    ex_lw_d     = 1'b0;
    ex_dst_d    = 5'd0;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_s) begin
      ex_wr_d  = 1'b0;
      ex_lw_d  = 1'b0;
      ex_dst_d = 5'd0;
    end else begin
      ex_wr_d  = wr_s;
      ex_lw_d  = is_lw_s;
      ex_dst_d = dst_s;
    end
    if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_s && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Tracking registers and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_wr_q     <= 1'b0;
      ex_lw_q     <= 1'b0;
      ex_dst_q    <= 5'd0;
      mem_lw_q    <= 1'b0;
      mem_dst_q   <= 5'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      ex_wr_q     <= ex_wr_d;
      ex_lw_q     <= ex_lw_d;
      ex_dst_q    <= ex_dst_d;
      mem_lw_q    <= ex_lw_q;
      mem_dst_q   <= ex_dst_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule
